level_event_det: RTL and testbench
==================================

# level_event_det

Downstream consumer of the `mean` smoothing stage. Watches the averaged 8-bit sample stream and maintains a slowly tracking baseline. It flags a level-change event when the input departs from that baseline by more than a threshold for a run of consecutive samples. On an event it reports the direction, re-acquires the baseline at the new level, and holds off further detection for a programmable number of samples.

## Interface
- `WIDTH`, 8, sample width (matches `mean` output)
- `THRESH`, 16, deviation magnitude that counts as exceeding (strictly greater than)
- `HOLD`, 3, consecutive same-direction exceeding samples required for an event (≥1)
- `HOLDOFF`, 4, samples after an event during which detection is suppressed (≥0)
- `SHIFT`, 2, baseline IIR shift (tracking gain 2^-SHIFT)
- `CNT_W`, 8, event counter width
- `clk`  in  1  clock, all logic on rising edge
- `rst`  in  1  reset, synchronous, active-high
- `en`  in  1  sample strobe; `in` is consumed only on cycles with `en`=1
- `in`  in  WIDTH  averaged sample (unsigned)
- `baseline`  out  WIDTH  current baseline estimate
- `event_pulse`  out  1  one-cycle event strobe
- `event_dir`  out  1  direction of last event: 1 = rise, 0 = fall
- `tracking`  out  1  high while FSM is in TRACK
- `event_cnt`  out  CNT_W  saturating event count

## Operation
- FSM states: INIT, TRACK, PEND, LOCK. Reset state is INIT.
- `diff` = `in` − `baseline`, signed WIDTH+1. Exceed means |diff| > THRESH. Sign gives the direction.
- INIT, on `en`:
  - `baseline` ← `in`; go to TRACK.
- TRACK, on `en`:
  - No exceed: `baseline` ← `baseline` + (`diff` >>> SHIFT), arithmetic shift, result clamped to [0, 2^WIDTH−1].
  - Exceed with HOLD=1: fire the event immediately.
  - Exceed with HOLD>1: latch the direction, run ← 1, go to PEND. Baseline is not updated.
- PEND, on `en`:
  - Exceed in the same direction: run ← run+1. When run reaches HOLD, fire the event.
  - No exceed, or exceed in the opposite direction: run ← 0, go to TRACK. Baseline is not updated on that sample.
- Event firing:
  - `event_pulse` ← 1 for one cycle.
  - `event_dir` ← direction.
  - `event_cnt` increments, saturating at all-ones.
  - `baseline` ← `in`.
  - Go to LOCK with holdoff counter ← HOLDOFF. If HOLDOFF=0, go to TRACK instead.
- LOCK, on `en`:
  - `baseline` ← `in`; counter decrements.
  - When the counter reaches 0, go to TRACK.
  - No detection occurs in LOCK.
- `en`=0: state, counters and `baseline` hold; `event_pulse` is 0.
- Upward tracking lags by up to 2^SHIFT−1 LSB (truncation toward −∞). This is accepted behaviour.

## Timing
- All outputs are registered.
- Reset values: `baseline`=0, `event_pulse`=0, `event_dir`=0, `tracking`=0, `event_cnt`=0. Run and holdoff counters are 0.
- Latency: `event_pulse` is high in the cycle after the clock edge that consumes the HOLD-th exceeding sample. `event_cnt`, `event_dir` and `baseline` update on that same edge.
- `baseline` reflects the sample consumed on the previous edge.
- `tracking` updates on the same edge as the state.
- |diff| == THRESH is not an exceed.
- Reset asserted mid-PEND or mid-LOCK: return to INIT on the next edge. No pulse, counters cleared.
- `en` gaps inside PEND or LOCK do not break the run or shorten the holdoff.

## Configuration
- `LEVEL_EVENT_DET_CNT_EN` defined: `event_cnt` register and saturating increment are present, as described above.
- Undefined: no counter logic. `event_cnt` is tied to 0. All other behaviour is unchanged.

## Test plan
- Reset, then `en`=1 with constant 124 for 10 cycles → `baseline`=124 after the first sample, `tracking`=1, `event_pulse` never high.
- From baseline 124, step to 0 for 5 samples (THRESH 16, HOLD 3, HOLDOFF 4) → `event_pulse` high exactly once, one cycle after the 3rd zero; `event_dir`=0, `event_cnt`=1, `baseline`=0; `tracking`=1 after 4 further samples.
- Glitch sequence 124,124,60,60,124 → PEND entered, then return to TRACK; no pulse; `baseline` stays 124.
- Baseline 120, inputs 136 then 137 (THRESH 16) → 136 is tracked (`baseline` becomes 124); 137 gives diff 13, no exceed.
- Step 124→200 with `en` toggling 1/0 each cycle → event fires after the 3rd enabled sample with `event_dir`=1; pulse is one cycle wide.
- CNT_W=2, macro defined, 5 alternating-level events → `event_cnt` reads 1, 2, 3, 3, 3. Same sequence with reset asserted mid-PEND → outputs return to reset values and no pulse occurs.

Source files
------------

// File: rtl/level_event_det.sv
// Level-change event detector: tracks a slow IIR baseline and flags sustained departures.
// Optional event counter enabled by defining LEVEL_EVENT_DET_CNT_EN.
module level_event_det #(
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned THRESH  = 16,
    parameter int unsigned HOLD    = 3,
    parameter int unsigned HOLDOFF = 4,
    parameter int unsigned SHIFT   = 2,
    parameter int unsigned CNT_W   = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             en_i,
    input  logic [WIDTH-1:0] in_i,
    output logic [WIDTH-1:0] baseline_o,
    output logic             event_pulse_o,
    output logic             event_dir_o,
    output logic             tracking_o,
    output logic [CNT_W-1:0] event_cnt_o
);

    // Two guard bits: one for the sign of diff, one to detect tracking overflow.
    localparam int unsigned DW    = WIDTH + 2;
    localparam int unsigned RUN_W = (HOLD > 1) ? $clog2(HOLD + 1) : 1;
    localparam int unsigned HO_W  = (HOLDOFF > 1) ? $clog2(HOLDOFF + 1) : 1;

    typedef enum logic [1:0] {S_INIT, S_TRACK, S_PEND, S_LOCK} state_t;

    state_t             state_q;
    logic [WIDTH-1:0]   base_q;
    logic               pulse_q;
    logic               pend_dir_q;
    logic               ev_dir_q;
    logic               track_q;
    logic [RUN_W-1:0]   run_q;
    logic [HO_W-1:0]    ho_q;

    logic signed [DW-1:0] diff_c;
    logic signed [DW-1:0] mag_c;
    logic signed [DW-1:0] trk_c;
    logic [WIDTH-1:0]     trk_sat_c;
    logic                 exceed_c;
    logic                 rise_c;
    logic                 fire_c;

    // Deviation, exceed/direction decode, clamped IIR step and event decision.
    always_comb begin
        diff_c   = $signed(DW'(in_i)) - $signed(DW'(base_q));
        mag_c    = diff_c[DW-1] ? -diff_c : diff_c;
        exceed_c = mag_c > $signed(DW'(THRESH));
        rise_c   = ~diff_c[DW-1];
        trk_c    = $signed(DW'(base_q)) + (diff_c >>> SHIFT);
        if (trk_c[DW-1]) begin
            trk_sat_c = '0;
        end else if (trk_c[DW-2]) begin
            trk_sat_c = '1;
        end else begin
            trk_sat_c = trk_c[WIDTH-1:0];
        end
        fire_c = 1'b0;
        if (en_i && exceed_c) begin
            if (state_q == S_TRACK && HOLD <= 1) begin
                fire_c = 1'b1;
            end
            if (state_q == S_PEND && rise_c == pend_dir_q && run_q == RUN_W'(HOLD - 1)) begin
                fire_c = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= S_INIT;
            base_q     <= '0;
            pulse_q    <= 1'b0;
            pend_dir_q <= 1'b0;
            ev_dir_q   <= 1'b0;
            track_q    <= 1'b0;
            run_q      <= '0;
            ho_q       <= '0;
        end else begin
            pulse_q <= 1'b0;
            if (en_i) begin
                case (state_q)
                    S_INIT: begin
                        base_q  <= in_i;
                        state_q <= S_TRACK;
                        track_q <= 1'b1;
                    end
                    S_TRACK: begin
                        if (!exceed_c) begin
                            base_q <= trk_sat_c;
                        end else if (!fire_c) begin
                            pend_dir_q <= rise_c;
                            run_q      <= RUN_W'(1);
                            state_q    <= S_PEND;
                            track_q    <= 1'b0;
                        end
                    end
                    S_PEND: begin
                        if (exceed_c && rise_c == pend_dir_q) begin
                            run_q <= run_q + 1'b1;
                        end else begin
                            run_q   <= '0;
                            state_q <= S_TRACK;
                            track_q <= 1'b1;
                        end
                    end
                    S_LOCK: begin
                        base_q <= in_i;
                        ho_q   <= ho_q - 1'b1;
                        if (ho_q <= HO_W'(1)) begin
                            state_q <= S_TRACK;
                            track_q <= 1'b1;
                        end
                    end
                    default: begin
                        state_q <= S_INIT;
                        track_q <= 1'b0;
                    end
                endcase
            end
            // Event overrides the per-state updates above.
            if (fire_c) begin
                pulse_q  <= 1'b1;
                ev_dir_q <= rise_c;
                base_q   <= in_i;
                run_q    <= '0;
                if (HOLDOFF == 0) begin
                    state_q <= S_TRACK;
                    track_q <= 1'b1;
                end else begin
                    state_q <= S_LOCK;
                    track_q <= 1'b0;
                    ho_q    <= HO_W'(HOLDOFF);
                end
            end
        end
    end

    assign baseline_o    = base_q;
    assign event_pulse_o = pulse_q;
    assign event_dir_o   = ev_dir_q;
    assign tracking_o    = track_q;

`ifdef LEVEL_EVENT_DET_CNT_EN
    logic [CNT_W-1:0] cnt_q;

    // Saturating event count.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else if (fire_c && cnt_q != '1) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign event_cnt_o = cnt_q;
`else
    assign event_cnt_o = '0;
`endif

endmodule

// File: tb/tb_level_event_det.sv
// Scoreboard bench for level_event_det: driver queues hand-computed per-cycle expectations,
// monitor compares after each rising edge.
module tb_level_event_det;

    logic       clk;
    logic       rst;
    logic       en;
    logic [7:0] in_s;
    logic [7:0] baseline;
    logic       event_pulse;
    logic       event_dir;
    logic       tracking;
    logic [1:0] event_cnt;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [7:0] b;
        logic       p;
        logic       d;
        logic       t;
        logic [1:0] c;
    } exp_t;

    exp_t exp_q[$];

    level_event_det #(
        .WIDTH(8), .THRESH(16), .HOLD(3), .HOLDOFF(4), .SHIFT(2), .CNT_W(2)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .en_i(en),
        .in_i(in_s),
        .baseline_o(baseline),
        .event_pulse_o(event_pulse),
        .event_dir_o(event_dir),
        .tracking_o(tracking),
        .event_cnt_o(event_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int want);
        checks++;
        if (act != want) begin
            errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, want);
        end
    endtask

    // Monitor: one expected response per driven cycle.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("baseline", int'(baseline), int'(e.b));
                chk("event_pulse", int'(event_pulse), int'(e.p));
                chk("event_dir", int'(event_dir), int'(e.d));
                chk("tracking", int'(tracking), int'(e.t));
                chk("event_cnt", int'(event_cnt), int'(e.c));
            end
        end
    end

    task automatic step(input logic r, input logic e, input logic [7:0] x,
                        input logic [7:0] b, input logic p, input logic d,
                        input logic t, input int c);
        exp_t ex;
        @(negedge clk);
        rst  = r;
        en   = e;
        in_s = x;
        ex.b = b;
        ex.p = p;
        ex.d = d;
        ex.t = t;
`ifdef LEVEL_EVENT_DET_CNT_EN
        ex.c = 2'(c);
`else
        ex.c = 2'(0 * c);
`endif
        exp_q.push_back(ex);
    endtask

    // Full event at a new level: 3 exceeding samples then 4 holdoff samples.
    task automatic ev(input logic [7:0] lvl, input logic [7:0] pb, input logic pdir,
                      input logic ndir, input int pc, input int nc);
        step(0, 1, lvl, pb, 0, pdir, 0, pc);
        step(0, 1, lvl, pb, 0, pdir, 0, pc);
        step(0, 1, lvl, lvl, 1, ndir, 0, nc);
        step(0, 1, lvl, lvl, 0, ndir, 0, nc);
        step(0, 1, lvl, lvl, 0, ndir, 0, nc);
        step(0, 1, lvl, lvl, 0, ndir, 0, nc);
        step(0, 1, lvl, lvl, 0, ndir, 1, nc);
    endtask

    initial begin
        rst  = 1'b1;
        en   = 1'b0;
        in_s = 8'd0;

        // Reset state
        step(1, 0, 0, 0, 0, 0, 0, 0);
        step(1, 1, 77, 0, 0, 0, 0, 0);

        // Constant 124
        for (int i = 0; i < 10; i++) step(0, 1, 124, 124, 0, 0, 1, 0);

        // Falling step to 0
        step(0, 1, 0, 124, 0, 0, 0, 0);
        step(0, 1, 0, 124, 0, 0, 0, 0);
        step(0, 1, 0, 0, 1, 0, 0, 1);
        step(0, 1, 0, 0, 0, 0, 0, 1);
        step(0, 1, 0, 0, 0, 0, 0, 1);
        step(0, 1, 0, 0, 0, 0, 0, 1);
        step(0, 1, 0, 0, 0, 0, 1, 1);

        // Glitch: PEND then back to TRACK, run must restart
        step(1, 0, 0, 0, 0, 0, 0, 0);
        step(0, 1, 124, 124, 0, 0, 1, 0);
        step(0, 1, 124, 124, 0, 0, 1, 0);
        step(0, 1, 60, 124, 0, 0, 0, 0);
        step(0, 1, 60, 124, 0, 0, 0, 0);
        step(0, 1, 124, 124, 0, 0, 1, 0);
        step(0, 1, 60, 124, 0, 0, 0, 0);
        step(0, 1, 60, 124, 0, 0, 0, 0);
        step(0, 1, 124, 124, 0, 0, 1, 0);

        // Tracking arithmetic and threshold boundary
        step(1, 0, 0, 0, 0, 0, 0, 0);
        step(0, 1, 120, 120, 0, 0, 1, 0);
        step(0, 1, 136, 124, 0, 0, 1, 0);
        step(0, 1, 137, 127, 0, 0, 1, 0);
        step(0, 1, 114, 123, 0, 0, 1, 0);
        step(0, 1, 140, 123, 0, 0, 0, 0);
        step(0, 1, 106, 123, 0, 0, 1, 0);

        // Rising step with en toggling
        step(1, 0, 0, 0, 0, 0, 0, 0);
        step(0, 1, 124, 124, 0, 0, 1, 0);
        step(0, 1, 200, 124, 0, 0, 0, 0);
        step(0, 0, 200, 124, 0, 0, 0, 0);
        step(0, 1, 200, 124, 0, 0, 0, 0);
        step(0, 0, 200, 124, 0, 0, 0, 0);
        step(0, 1, 200, 200, 1, 1, 0, 1);
        step(0, 0, 200, 200, 0, 1, 0, 1);
        step(0, 1, 200, 200, 0, 1, 0, 1);
        step(0, 0, 200, 200, 0, 1, 0, 1);
        step(0, 1, 200, 200, 0, 1, 0, 1);
        step(0, 1, 200, 200, 0, 1, 0, 1);
        step(0, 1, 200, 200, 0, 1, 1, 1);
        step(0, 0, 0, 200, 0, 1, 1, 1);

        // Five alternating events, counter saturates at 3
        step(1, 0, 0, 0, 0, 0, 0, 0);
        step(0, 1, 124, 124, 0, 0, 1, 0);
        ev(20, 124, 0, 0, 0, 1);
        ev(200, 20, 0, 1, 1, 2);
        ev(20, 200, 1, 0, 2, 3);
        ev(200, 20, 0, 1, 3, 3);
        ev(20, 200, 1, 0, 3, 3);

        // Reset mid-PEND
        step(0, 1, 200, 20, 0, 0, 0, 3);
        step(0, 1, 200, 20, 0, 0, 0, 3);
        step(1, 1, 200, 0, 0, 0, 0, 0);
        step(0, 1, 200, 200, 0, 0, 1, 0);
        step(0, 1, 200, 200, 0, 0, 1, 0);

        for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clk);
        #2;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
